// File: rtl/mips_pkg.sv
// Shared MIPS ALU encodings: alu_op, R-type funct and ALUCon codes.
// Used by the ID/EX stage, its ALU-control decoder and the ALU.
package mips_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ORI   = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALUCON_AND = 4'b0000;
    localparam logic [3:0] ALUCON_OR  = 4'b0001;
    localparam logic [3:0] ALUCON_ADD = 4'b0010;
    localparam logic [3:0] ALUCON_SUB = 4'b0110;
    localparam logic [3:0] ALUCON_SLT = 4'b0111;
    localparam logic [3:0] ALUCON_NOR = 4'b1100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Register 0 is hard-wired, so a write-back to it never forwards.
    function automatic logic fwd_hit(
        input logic       we,
        input logic [4:0] dest,
        input logic [4:0] src
    );
        return we && (dest == src) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID/EX stage handshake, operand and write-back signals.
// master = decode/pipeline side driving the stage, slave = the stage.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [31:0] in_imm;
    logic        in_alu_src;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_dest;
    logic        in_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dest;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dest;
    logic [31:0] memwb_result;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  alu_con;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  out_dest;
    logic        out_reg_write;
    logic        out_illegal;

    modport master (
        output in_valid, in_alu_op, in_funct,
        output in_rs_data, in_rt_data, in_imm,
        output in_alu_src, in_rs, in_rt,
        output in_dest, in_reg_write,
        output exmem_reg_write, exmem_dest, exmem_result,
        output memwb_reg_write, memwb_dest, memwb_result,
        output flush, out_ready,
        input  in_ready, out_valid, alu_con,
        input  data_a, data_b, out_dest,
        input  out_reg_write, out_illegal
    );

    modport slave (
        input  in_valid, in_alu_op, in_funct,
        input  in_rs_data, in_rt_data, in_imm,
        input  in_alu_src, in_rs, in_rt,
        input  in_dest, in_reg_write,
        input  exmem_reg_write, exmem_dest, exmem_result,
        input  memwb_reg_write, memwb_dest, memwb_result,
        input  flush, out_ready,
        output in_ready, out_valid, alu_con,
        output data_a, data_b, out_dest,
        output out_reg_write, out_illegal
    );

endinterface

// File: rtl/id_ex_stage_alu_control.sv
// Combinational ALU-control decoder: alu_op + funct -> ALUCon.
// Unknown R-type funct falls back to ADD and flags illegal.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_con,
    output logic       illegal
);

    always_comb begin
        alu_con = ALUCON_ADD;
        illegal = 1'b0;
        unique case (alu_op_e'(alu_op))
            ALU_OP_ADD: alu_con = ALUCON_ADD;
            ALU_OP_SUB: alu_con = ALUCON_SUB;
            ALU_OP_ORI: alu_con = ALUCON_OR;
            ALU_OP_RTYPE: begin
                unique case (funct)
                    FUNCT_ADD: alu_con = ALUCON_ADD;
                    FUNCT_SUB: alu_con = ALUCON_SUB;
                    FUNCT_AND: alu_con = ALUCON_AND;
                    FUNCT_OR:  alu_con = ALUCON_OR;
                    FUNCT_NOR: alu_con = ALUCON_NOR;
                    FUNCT_SLT: alu_con = ALUCON_SLT;
                    default: begin
                        alu_con = ALUCON_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: alu_con = ALUCON_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// One-entry ID/EX pipeline register with valid/ready handshake and flush.
// Define FORWARDING_EN to forward EX/MEM and MEM/WB results to operands.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_alu_op,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    input  logic [31:0] in_imm,
    input  logic        in_alu_src,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_dest,
    input  logic        in_reg_write,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_dest,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_dest,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  alu_con,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    output logic [4:0]  out_dest,
    output logic        out_reg_write,
    output logic        out_illegal
);

    stage_state_e state_q, state_d;
    logic [3:0]   alu_con_q, alu_con_d;
    logic [31:0]  data_a_q, data_a_d;
    logic [31:0]  data_b_q, data_b_d;
    logic [4:0]   dest_q, dest_d;
    logic         reg_write_q, reg_write_d;
    logic         illegal_q, illegal_d;

    logic [3:0]   dec_con;
    logic         dec_illegal;
    logic [31:0]  rs_fwd;
    logic [31:0]  rt_fwd;
    logic         capture;

    alu_control u_alu_control (
        .alu_op  (in_alu_op),
        .funct   (in_funct),
        .alu_con (dec_con),
        .illegal (dec_illegal)
    );

`ifdef FORWARDING_EN
    // EX/MEM holds the younger result, so it is checked first.
    always_comb begin
        rs_fwd = in_rs_data;
        rt_fwd = in_rt_data;
        if (fwd_hit(exmem_reg_write, exmem_dest, in_rs))
            rs_fwd = exmem_result;
        else if (fwd_hit(memwb_reg_write, memwb_dest, in_rs))
            rs_fwd = memwb_result;
        if (fwd_hit(exmem_reg_write, exmem_dest, in_rt))
            rt_fwd = exmem_result;
        else if (fwd_hit(memwb_reg_write, memwb_dest, in_rt))
            rt_fwd = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_dest,
                          exmem_result, memwb_reg_write,
                          memwb_dest, memwb_result,
                          in_rs, in_rt};
    assign rs_fwd = in_rs_data;
    assign rt_fwd = in_rt_data;
`endif

    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = ST_EMPTY;
        else if (capture)
            state_d = ST_FULL;
        else if (state_q == ST_FULL && out_ready)
            state_d = ST_EMPTY;
    end

    always_comb begin
        alu_con_d   = alu_con_q;
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (capture) begin
            alu_con_d   = dec_con;
            data_a_d    = rs_fwd;
            data_b_d    = in_alu_src ? in_imm : rt_fwd;
            dest_d      = in_dest;
            reg_write_d = in_reg_write && !dec_illegal;
            illegal_d   = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            alu_con_q   <= 4'd0;
            data_a_q    <= 32'd0;
            data_b_q    <= 32'd0;
            dest_q      <= 5'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_con_q   <= alu_con_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid     = (state_q == ST_FULL);
    assign alu_con       = alu_con_q;
    assign data_a        = data_a_q;
    assign data_b        = data_b_q;
    assign out_dest      = dest_q;
    assign out_reg_write = reg_write_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (default and FORWARDING_EN).
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (bus.in_valid),
        .in_ready        (bus.in_ready),
        .in_alu_op       (bus.in_alu_op),
        .in_funct        (bus.in_funct),
        .in_rs_data      (bus.in_rs_data),
        .in_rt_data      (bus.in_rt_data),
        .in_imm          (bus.in_imm),
        .in_alu_src      (bus.in_alu_src),
        .in_rs           (bus.in_rs),
        .in_rt           (bus.in_rt),
        .in_dest         (bus.in_dest),
        .in_reg_write    (bus.in_reg_write),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_dest      (bus.exmem_dest),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_dest      (bus.memwb_dest),
        .memwb_result    (bus.memwb_result),
        .flush           (bus.flush),
        .out_ready       (bus.out_ready),
        .out_valid       (bus.out_valid),
        .alu_con         (bus.alu_con),
        .data_a          (bus.data_a),
        .data_b          (bus.data_b),
        .out_dest        (bus.out_dest),
        .out_reg_write   (bus.out_reg_write),
        .out_illegal     (bus.out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op,
                         input logic [5:0] fn,
                         input logic [31:0] rsd,
                         input logic [31:0] rtd);
        bus.in_valid     = 1'b1;
        bus.in_alu_op    = op;
        bus.in_funct     = fn;
        bus.in_rs_data   = rsd;
        bus.in_rt_data   = rtd;
        bus.in_alu_src   = 1'b0;
        bus.in_imm       = 32'h0;
        bus.in_rs        = 5'd1;
        bus.in_rt        = 5'd2;
        bus.in_dest      = 5'd3;
        bus.in_reg_write = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".con"}, 32'(bus.alu_con), 32'd0);
        check({tag, ".a"}, bus.data_a, 32'd0);
        check({tag, ".b"}, bus.data_b, 32'd0);
        check({tag, ".dest"}, 32'(bus.out_dest), 32'd0);
        check({tag, ".rw"}, 32'(bus.out_reg_write), 32'd0);
        check({tag, ".ill"}, 32'(bus.out_illegal), 32'd0);
    endtask

    logic [1:0]  v_op  [6];
    logic [5:0]  v_fn  [6];
    logic [3:0]  v_con [6];
    logic [31:0] fwd_exp;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        v_op[0] = 2'b01; v_fn[0] = 6'b000000; v_con[0] = 4'b0110;
        v_op[1] = 2'b11; v_fn[1] = 6'b000000; v_con[1] = 4'b0001;
        v_op[2] = 2'b10; v_fn[2] = 6'b100010; v_con[2] = 4'b0110;
        v_op[3] = 2'b10; v_fn[3] = 6'b100101; v_con[3] = 4'b0001;
        v_op[4] = 2'b10; v_fn[4] = 6'b100111; v_con[4] = 4'b1100;
        v_op[5] = 2'b10; v_fn[5] = 6'b100100; v_con[5] = 4'b0000;

        rst_n = 1'b0;
        drive(2'b00, 6'd0, 32'h0, 32'h0);
        bus.in_valid        = 1'b0;
        bus.in_reg_write    = 1'b0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_dest      = 5'd0;
        bus.exmem_result    = 32'h0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_dest      = 5'd0;
        bus.memwb_result    = 32'h0;
        bus.flush           = 1'b0;
        bus.out_ready       = 1'b1;
        step();
        step();
        check_zero("reset");
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // add with register operands
        drive(2'b10, 6'b100000, 32'd2, 32'd1);
        step();
        check("add.valid", 32'(bus.out_valid), 32'd1);
        check("add.con", 32'(bus.alu_con), 32'b0010);
        check("add.a", bus.data_a, 32'd2);
        check("add.b", bus.data_b, 32'd1);
        check("add.dest", 32'(bus.out_dest), 32'd3);
        check("add.rw", 32'(bus.out_reg_write), 32'd1);
        check("add.ill", 32'(bus.out_illegal), 32'd0);

        // slt, then stall three cycles with new inputs presented
        drive(2'b10, 6'b101010, 32'd7, 32'd9);
        step();
        check("slt.con", 32'(bus.alu_con), 32'b0111);
        bus.out_ready = 1'b0;
        drive(2'b10, 6'b100100, 32'h55, 32'h66);
        #1;
        check("stall.in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.valid", 32'(bus.out_valid), 32'd1);
            check("stall.con", 32'(bus.alu_con), 32'b0111);
            check("stall.a", bus.data_a, 32'd7);
            check("stall.b", bus.data_b, 32'd9);
            check("stall.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("and.con", 32'(bus.alu_con), 32'b0000);
        check("and.a", bus.data_a, 32'h55);
        check("and.b", bus.data_b, 32'h66);

        // illegal funct
        drive(2'b10, 6'b111111, 32'd4, 32'd5);
        step();
        check("ill.ill", 32'(bus.out_illegal), 32'd1);
        check("ill.con", 32'(bus.alu_con), 32'b0010);
        check("ill.rw", 32'(bus.out_reg_write), 32'd0);

        // immediate operand
        drive(2'b00, 6'd0, 32'd10, 32'h1234);
        bus.in_alu_src = 1'b1;
        bus.in_imm     = 32'hFFFF_FFFC;
        step();
        check("imm.con", 32'(bus.alu_con), 32'b0010);
        check("imm.b", bus.data_b, 32'hFFFF_FFFC);
        check("imm.a", bus.data_a, 32'd10);
        check("imm.ill", 32'(bus.out_illegal), 32'd0);

        // remaining decode table
        for (int i = 0; i < 6; i++) begin
            drive(v_op[i], v_fn[i], 32'd1, 32'd1);
            step();
            check("dec.con", 32'(bus.alu_con), 32'(v_con[i]));
            check("dec.ill", 32'(bus.out_illegal), 32'd0);
        end

        // forwarding: both stages write r5
        drive(2'b00, 6'd0, 32'h1111, 32'h2222);
        bus.in_rs           = 5'd5;
        bus.in_rt           = 5'd5;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_dest      = 5'd5;
        bus.exmem_result    = 32'hAAAA;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_dest      = 5'd5;
        bus.memwb_result    = 32'hBBBB;
        step();
`ifdef FORWARDING_EN
        fwd_exp = 32'hAAAA;
`else
        fwd_exp = 32'h1111;
`endif
        check("fwd.both.a", bus.data_a, fwd_exp);
`ifdef FORWARDING_EN
        fwd_exp = 32'hAAAA;
`else
        fwd_exp = 32'h2222;
`endif
        check("fwd.both.b", bus.data_b, fwd_exp);
        bus.exmem_reg_write = 1'b0;
        step();
`ifdef FORWARDING_EN
        fwd_exp = 32'hBBBB;
`else
        fwd_exp = 32'h1111;
`endif
        check("fwd.memwb.a", bus.data_a, fwd_exp);
        bus.exmem_reg_write = 1'b1;
        bus.in_rs           = 5'd0;
        bus.exmem_dest      = 5'd0;
        bus.memwb_dest      = 5'd0;
        step();
        check("fwd.r0.a", bus.data_a, 32'h1111);
        bus.exmem_reg_write = 1'b0;
        bus.memwb_reg_write = 1'b0;

        // drain with no new input
        bus.in_valid = 1'b0;
        step();
        check("drain.valid", 32'(bus.out_valid), 32'd0);
        check("drain.a", bus.data_a, 32'h1111);

        // flush while FULL with concurrent input
        drive(2'b01, 6'd0, 32'h77, 32'h88);
        step();
        check("pre_flush.valid", 32'(bus.out_valid), 32'd1);
        drive(2'b10, 6'b100111, 32'h99, 32'hAA);
        bus.flush = 1'b1;
        step();
        check("flush.valid", 32'(bus.out_valid), 32'd0);
        check("flush.a", bus.data_a, 32'h77);
        check("flush.con", 32'(bus.alu_con), 32'b0110);
        bus.flush = 1'b0;

        // reset in the middle of a stall
        drive(2'b11, 6'd0, 32'h5, 32'h6);
        bus.out_ready = 1'b0;
        step();
        check("pre_rst.valid", 32'(bus.out_valid), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        check_zero("mid_rst");
        rst_n = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("post_rst.valid", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
